// File: rtl/rv_dec_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU op codes,
// the immediate-format enum and the decoded control bundle.
package rv_dec_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASS_B = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd16;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_muldiv;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        illegal;
  } dec_bundle_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:   imm_gen = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm_gen = {i[31:12], 12'b0};
      IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_gen = 32'b0;
    endcase
  endfunction

  // Base-ISA ALU op selected by funct3 alone (funct7 alternates handled by caller).
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: alu_from_f3 = ALU_ADD;
      F3_SLL:     alu_from_f3 = ALU_SLL;
      F3_SLT:     alu_from_f3 = ALU_SLT;
      F3_SLTU:    alu_from_f3 = ALU_SLTU;
      F3_XOR:     alu_from_f3 = ALU_XOR;
      F3_SRL_SRA: alu_from_f3 = ALU_SRL;
      F3_OR:      alu_from_f3 = ALU_OR;
      default:    alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_dec_core.sv
// Combinational RV32I instruction-word decoder.
// DEC_RV32M_EN enables decode of the RV32M multiply/divide group.
module rv32_dec_core
  import rv_dec_pkg::*;
(
  input  logic [31:0]  inst,
  output dec_bundle_t  dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_fmt_e   fmt;
  logic       ill;
  logic       use_rd;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  always_comb begin
    // NOTE: every variable gets a default here so no path through the case infers a latch.
    dec    = '0;
    fmt    = IMM_NONE;
    ill    = 1'b0;
    use_rd = 1'b0;
    // Opcode constants all end in 2'b11, so compressed encodings fall to default.
    case (opcode)
      OPC_LUI:   begin use_rd = 1'b1; fmt = IMM_U; dec.alu_op = ALU_PASS_B; end
      OPC_AUIPC: begin use_rd = 1'b1; fmt = IMM_U; dec.alu_op = ALU_ADD; end
      OPC_JAL:   begin use_rd = 1'b1; fmt = IMM_J; dec.is_jump = 1'b1; end
      OPC_JALR: begin
        use_rd = 1'b1; fmt = IMM_I; dec.rs1_used = 1'b1; dec.is_jump = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = IMM_B; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.is_branch = 1'b1;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        dec.alu_op = (f3[2] == 1'b0) ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      OPC_LOAD: begin
        use_rd = 1'b1; fmt = IMM_I; dec.rs1_used = 1'b1; dec.is_load = 1'b1;
        dec.mem_size = f3[1:0]; dec.mem_unsigned = f3[2];
        ill = (f3[1:0] == 2'b11) || (f3 == 3'b110);
      end
      OPC_STORE: begin
        fmt = IMM_S; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.is_store = 1'b1;
        dec.mem_size = f3[1:0];
        ill = f3[2] || (f3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        use_rd = 1'b1; fmt = IMM_I; dec.rs1_used = 1'b1;
        dec.alu_op = alu_from_f3(f3);
        if (f3 == F3_SLL) ill = (f7 != F7_BASE);
        else if (f3 == F3_SRL_SRA) begin
          if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
          else ill = (f7 != F7_BASE);
        end
      end
      OPC_OP: begin
        use_rd = 1'b1; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
        dec.alu_op = alu_from_f3(f3);
        if (f7 == F7_ALT) begin
          if (f3 == F3_ADD_SUB) dec.alu_op = ALU_SUB;
          else if (f3 == F3_SRL_SRA) dec.alu_op = ALU_SRA;
          else ill = 1'b1;
        end else if (f7 == F7_MULDIV) begin
`ifdef DEC_RV32M_EN
          dec.alu_op    = ALU_MUL + {2'b00, f3};
          dec.is_muldiv = 1'b1;
`else
          ill = 1'b1;
`endif
        end else begin
          ill = (f7 != F7_BASE);
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: dec.alu_op = ALU_ADD;
      default: ill = 1'b1;
    endcase

    dec.imm   = imm_gen(inst, fmt);
    dec.rd    = use_rd ? inst[11:7] : 5'd0;
    dec.rs1   = dec.rs1_used ? inst[19:15] : 5'd0;
    dec.rs2   = dec.rs2_used ? inst[24:20] : 5'd0;
    dec.rd_we = use_rd && (inst[11:7] != 5'd0);

    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a 2-entry (output + skid) buffer.
// DEC_RV32M_EN enables RV32M decode inside rv32_dec_core.
module rv_decode_stage
  import rv_dec_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int TAG_W    = 4,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [TAG_W-1:0]    out_tag,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic                out_rd_we,
  output logic                out_rs1_used,
  output logic                out_rs2_used,
  output logic [31:0]         out_imm,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_is_load,
  output logic                out_is_store,
  output logic                out_is_branch,
  output logic                out_is_jump,
  output logic                out_is_muldiv,
  output logic [1:0]          out_mem_size,
  output logic                out_mem_unsigned,
  output logic                out_illegal
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
    dec_bundle_t      dec;
  } entry_t;

  // Encoding chosen so bit 0 is out_valid and bit 1 is skid-full, both direct flops.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b11;

  logic [1:0]  state;
  entry_t      out_q;
  entry_t      skid_q;
  entry_t      in_ent;
  dec_bundle_t in_dec;
  logic        accept;
  logic        deliver;

  rv32_dec_core u_dec (
    .inst (in_inst),
    .dec  (in_dec)
  );

  assign in_ent    = '{pc: in_pc, tag: in_tag, dec: in_dec};
  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          out_q <= in_ent;
          state <= ST_FULL;
        end
        ST_FULL: begin
          if (accept && !deliver) begin
            skid_q <= in_ent;
            state  <= ST_SKID;
          end else if (accept && deliver) begin
            out_q <= in_ent;
          end else if (deliver) begin
            state <= ST_EMPTY;
          end
        end
        ST_SKID: if (deliver) begin
          out_q <= skid_q;
          state <= ST_FULL;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign out_pc           = out_q.pc;
  assign out_tag          = out_q.tag;
  assign out_rd           = out_q.dec.rd;
  assign out_rs1          = out_q.dec.rs1;
  assign out_rs2          = out_q.dec.rs2;
  assign out_rd_we        = out_q.dec.rd_we;
  assign out_rs1_used     = out_q.dec.rs1_used;
  assign out_rs2_used     = out_q.dec.rs2_used;
  assign out_imm          = out_q.dec.imm;
  assign out_alu_op       = ALU_OP_W'(out_q.dec.alu_op);
  assign out_is_load      = out_q.dec.is_load;
  assign out_is_store     = out_q.dec.is_store;
  assign out_is_branch    = out_q.dec.is_branch;
  assign out_is_jump      = out_q.dec.is_jump;
  assign out_is_muldiv    = out_q.dec.is_muldiv;
  assign out_mem_size     = out_q.dec.mem_size;
  assign out_mem_unsigned = out_q.dec.mem_unsigned;
  assign out_illegal      = out_q.dec.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage (decode, backpressure, flush, reset).
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, out_imm;
  logic [31:0] in_pc, out_pc;
  logic [3:0]  in_tag, out_tag, out_mem_dummy;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_op;
  logic        out_rd_we, out_rs1_used, out_rs2_used;
  logic        out_is_load, out_is_store, out_is_branch, out_is_jump, out_is_muldiv;
  logic [1:0]  out_mem_size;
  logic        out_mem_unsigned, out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  assign out_mem_dummy = 4'd0;

  rv_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_tag(out_tag),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_imm(out_imm), .out_alu_op(out_alu_op),
    .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_is_muldiv(out_is_muldiv), .out_mem_size(out_mem_size),
    .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [3:0] tag);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    in_tag   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_imm",       out_imm, 0);
    check("rst_pc",        out_pc, 0);

    // ADDI x1, x0, 5 -- valid exactly one cycle after accept
    drive(1'b1, 32'h00500093, 32'h100, 4'h1);
    check("addi_pre_valid", out_valid, 0);
    tick();
    check("addi_valid",  out_valid, 1);
    check("addi_rd",     out_rd, 1);
    check("addi_rs1",    out_rs1, 0);
    check("addi_imm",    out_imm, 5);
    check("addi_alu",    out_alu_op, 0);
    check("addi_rd_we",  out_rd_we, 1);
    check("addi_ill",    out_illegal, 0);
    check("addi_pc",     out_pc, 32'h100);
    check("addi_tag",    out_tag, 1);

    // BEQ x1, x2, -4
    drive(1'b1, 32'hFE208EE3, 32'h104, 4'h2);
    tick();
    check("beq_branch", out_is_branch, 1);
    check("beq_rs1",    out_rs1, 1);
    check("beq_rs2",    out_rs2, 2);
    check("beq_imm",    out_imm, 32'hFFFFFFFC);
    check("beq_rd_we",  out_rd_we, 0);

    // LUI x10, 0x12345
    drive(1'b1, 32'h12345537, 32'h108, 4'h3);
    tick();
    check("lui_rd",   out_rd, 10);
    check("lui_imm",  out_imm, 32'h12345000);
    check("lui_alu",  out_alu_op, 10);
    check("lui_rs1u", out_rs1_used, 0);

    // LBU x5, -1(x2)
    drive(1'b1, 32'hFFF14283, 32'h10C, 4'h4);
    tick();
    check("lbu_load", out_is_load, 1);
    check("lbu_size", out_mem_size, 0);
    check("lbu_uns",  out_mem_unsigned, 1);
    check("lbu_imm",  out_imm, 32'hFFFFFFFF);
    check("lbu_rd",   out_rd, 5);

    // SW x3, 8(x1)
    drive(1'b1, 32'h0030A423, 32'h110, 4'h5);
    tick();
    check("sw_store", out_is_store, 1);
    check("sw_size",  out_mem_size, 2);
    check("sw_imm",   out_imm, 8);
    check("sw_rd_we", out_rd_we, 0);
    check("sw_rs2",   out_rs2, 3);

    // SLL with funct7=0100000 is illegal
    drive(1'b1, 32'h401090B3, 32'h114, 4'h6);
    tick();
    check("badf7_ill",   out_illegal, 1);
    check("badf7_rd_we", out_rd_we, 0);

    // All-zero word: compressed quadrant, illegal
    drive(1'b1, 32'h00000000, 32'h118, 4'h7);
    tick();
    check("zero_valid", out_valid, 1);
    check("zero_ill",   out_illegal, 1);
    check("zero_rd_we", out_rd_we, 0);
    check("zero_flags", {out_is_load, out_is_store, out_is_branch, out_is_jump, out_is_muldiv}, 0);

    // MUL x3, x1, x2
    drive(1'b1, 32'h022081B3, 32'h11C, 4'h8);
    tick();
`ifdef DEC_RV32M_EN
    check("mul_muldiv", out_is_muldiv, 1);
    check("mul_alu",    out_alu_op, 16);
    check("mul_rd",     out_rd, 3);
    check("mul_ill",    out_illegal, 0);
`else
    check("mul_ill",    out_illegal, 1);
    check("mul_muldiv", out_is_muldiv, 0);
`endif

    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("drain_valid", out_valid, 0);

    // Backpressure: pc 0x0, 0x4, 0x8 with out_ready low for three cycles
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h0, 4'h0);
    tick();
    check("bp_ready_1", in_ready, 1);
    drive(1'b1, 32'h00000013, 32'h4, 4'h1);
    tick();
    check("bp_ready_2", in_ready, 0);
    drive(1'b1, 32'h00000013, 32'h8, 4'h2);
    tick();
    check("bp_hold_pc",   out_pc, 32'h0);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    check("bp_out0", out_pc, 32'h0);
    tick();
    check("bp_out4", out_pc, 32'h4);
    check("bp_ready_back", in_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("bp_out8", out_pc, 32'h8);
    check("bp_out8_valid", out_valid, 1);
    tick();
    check("bp_empty", out_valid, 0);

    // Flush while in SKID with a new instruction offered
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h20, 4'h0);
    tick();
    drive(1'b1, 32'h00000013, 32'h24, 4'h1);
    tick();
    check("fl_skid", in_ready, 0);
    drive(1'b1, 32'h00000013, 32'h28, 4'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (out_valid) seen++;
      end
      check("fl_no_ghost", seen, 0);
    end
    drive(1'b1, 32'h00000013, 32'h30, 4'h3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("fl_fresh_pc", out_pc, 32'h30);

    // Reset mid-stream with the stage in SKID
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h40, 4'h9);
    tick();
    drive(1'b1, 32'h00500093, 32'h44, 4'hA);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("mrst_valid", out_valid, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_pc",    out_pc, 0);
    check("mrst_imm",   out_imm, 0);
    check("mrst_rd",    out_rd, 0);
    check("mrst_tag",   out_tag, 0);
    check("mrst_rd_we", out_rd_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
